// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer with 2-entry prefetch buffer and PC
// Fetches over req/ack into a FIFO whose head feeds the control FSM; done pops, en rewinds.
module instr_fetch_ctrl #(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] rewind_addr,
  input  logic          done,
  input  logic          en,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  output logic [15:0]   fncode,
  output logic          instr_valid,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] rewind_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   buf0_q, buf0_d;
  logic [15:0]   buf1_q, buf1_d;
  logic [1:0]    count_q, count_d;
  logic          push;
  logic          pop;

  // A rewind overrides both the incoming word and any pop in the same cycle.
  assign push = (state_q == FETCH) && mem_ack && !en;
  assign pop  = done && (count_q != 2'd0) && !en;

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (en) begin
      count_d = 2'd0;
      pc_d    = rewind_addr;
    end else begin
      if (pop) pc_d = pc_q + 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf0_d = mem_data;
          else                 buf1_d = mem_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          buf0_d  = buf1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf0_d = mem_data;
          end else begin
            buf0_d = buf1_q;
            buf1_d = mem_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      count_q <= 2'd0;
      pc_q    <= RESET_PC;
    end else begin
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  // DRAIN keeps the abandoned request alive with its old address until memory accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      rewind_q   <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            mem_addr_q <= rewind_addr;
          end else if (run && (count_q < 2'd2)) begin
            mem_req_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
            mem_addr_q <= en ? rewind_addr : mem_addr_q + 1'b1;
          end else if (en) begin
            rewind_q <= rewind_addr;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
            mem_addr_q <= en ? rewind_addr : rewind_q;
          end else if (en) begin
            rewind_q <= rewind_addr;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (count_q != 2'd0);
  assign fncode      = (count_q != 2'd0) ? buf0_q : 16'h0000;
  assign pc          = pc_q;

endmodule
